// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - AXI4-Lite response codes and master FSM state encoding
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_WR    = 3'd1;
  localparam logic [ST_W-1:0] ST_WRESP = 3'd2;
  localparam logic [ST_W-1:0] ST_RD    = 3'd3;
  localparam logic [ST_W-1:0] ST_RDATA = 3'd4;
  localparam logic [ST_W-1:0] ST_RSP   = 3'd5;

  function automatic logic is_busy(input logic [ST_W-1:0] st);
    return (st == ST_WR) || (st == ST_WRESP) || (st == ST_RD) || (st == ST_RDATA);
  endfunction

endpackage

// File: rtl/axi_lite_master_cmd.sv
// rtl/axi_lite_master_cmd.sv - AXI4-Lite master turning single-word commands into transactions
module axi_lite_master_cmd
  import axi_lite_pkg::*;
#(
  parameter int         C_M_AXI_ADDR_WIDTH = 32,
  parameter int         C_M_AXI_DATA_WIDTH = 32,
  parameter logic [2:0] C_AXPROT           = 3'b000,
  parameter int         C_LAT_WIDTH        = 16
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_write,
  output logic [C_LAT_WIDTH-1:0]            rsp_latency,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;
  localparam int LW = C_LAT_WIDTH;

  logic [ST_W-1:0] state;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic            write_q;
  logic            awvalid_q;
  logic            wvalid_q;
  logic            bready_q;
  logic            arvalid_q;
  logic            rready_q;
  logic            aw_done;
  logic            w_done;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      resp_q;
  logic [LW-1:0]   lat_q;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;

  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q & M_AXI_WREADY;
  assign ar_hs = arvalid_q & M_AXI_ARREADY;

  // Main FSM: one outstanding command, captured registers drive the AXI channels.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            write_q <= cmd_write;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= ST_WR;
            end else begin
              arvalid_q <= 1'b1;
              state     <= ST_RD;
            end
          end
        end
        ST_WR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          // AW and W may finish in either order or together.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready_q <= 1'b1;
            state    <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (M_AXI_BVALID) begin
            bready_q <= 1'b0;
            resp_q   <= M_AXI_BRESP;
            state    <= ST_RSP;
          end
        end
        ST_RD: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (M_AXI_RVALID) begin
            rready_q <= 1'b0;
            rdata_q  <= M_AXI_RDATA;
            resp_q   <= M_AXI_RRESP;
            state    <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Latency counts every busy cycle, including the B/R handshake cycle, and sticks at all-ones.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      lat_q <= '0;
    end else if (state == ST_IDLE && cmd_valid) begin
      lat_q <= '0;
    end else if (is_busy(state) && lat_q != {LW{1'b1}}) begin
      lat_q <= lat_q + {{(LW-1){1'b0}}, 1'b1};
    end
  end

  assign cmd_ready     = (state == ST_IDLE);
  assign rsp_valid     = (state == ST_RSP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_write     = write_q;
  assign rsp_latency   = lat_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = C_AXPROT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = C_AXPROT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// tb/tb_axi_lite_master_cmd.sv - directed bench for axi_lite_master_cmd with a behavioural AXI4-Lite slave
module tb_axi_lite_master_cmd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_write;
  logic [15:0] rsp_latency;
  logic [31:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  int checks = 0;
  int failures = 0;

  bit rnd = 1'b0;
  bit hold_b = 1'b0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  axi_lite_master_cmd dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .rsp_latency(rsp_latency),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // Behavioural slave: 256-word memory, optional random ready/valid waits, SLVERR on read of 0x3FC.
  logic [31:0] mem [0:255];
  bit got_aw, got_w, b_pend, aw_n, w_n;

  always @(posedge clk) begin
    if (rst) begin
      M_AXI_AWREADY <= 1'b0; M_AXI_WREADY <= 1'b0; M_AXI_ARREADY <= 1'b0;
      M_AXI_BVALID <= 1'b0; M_AXI_RVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RDATA <= '0; M_AXI_RRESP <= 2'b00;
      got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      M_AXI_AWREADY <= rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      M_AXI_WREADY  <= rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      M_AXI_ARREADY <= rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
      if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
      aw_n = got_aw | (M_AXI_AWVALID & M_AXI_AWREADY);
      w_n  = got_w  | (M_AXI_WVALID & M_AXI_WREADY);
      if (aw_n && w_n) begin
        for (int i = 0; i < 4; i++)
          if (M_AXI_WSTRB[i]) mem[M_AXI_AWADDR[9:2]][8*i +: 8] <= M_AXI_WDATA[8*i +: 8];
        got_aw <= 1'b0; got_w <= 1'b0;
        M_AXI_BRESP <= 2'b00;
        if (!hold_b && (!rnd || $urandom_range(0, 1) == 1)) M_AXI_BVALID <= 1'b1;
        else b_pend <= 1'b1;
      end else begin
        got_aw <= aw_n; got_w <= w_n;
      end
      if (b_pend && !hold_b && (!rnd || $urandom_range(0, 1) == 1)) begin
        M_AXI_BVALID <= 1'b1; b_pend <= 1'b0;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= mem[M_AXI_ARADDR[9:2]];
        M_AXI_RRESP  <= (M_AXI_ARADDR == 32'h3FC) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Protocol monitor: VALIDs held until handshake, no BREADY while AW/W still pending.
  bit p_awv, p_awr, p_wv, p_wr;
  always @(negedge clk) begin
    if (mon_en) begin
      if (p_awv && !p_awr) chk("awvalid_held", M_AXI_AWVALID, 1);
      if (p_wv && !p_wr) chk("wvalid_held", M_AXI_WVALID, 1);
      if (M_AXI_AWVALID || M_AXI_WVALID) chk("bready_early", M_AXI_BREADY, 0);
    end
    p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY;
    p_wv  = M_AXI_WVALID;  p_wr  = M_AXI_WREADY;
  end

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("cmd_accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 500) begin @(negedge clk); cyc++; end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] model [0:255];
  logic [31:0] d, exp_d;
  logic [3:0]  s;
  int          idx, cyc, n;

  initial begin
    for (int i = 0; i < 256; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid}, 0);
    chk("reset_rsp", {rsp_rdata, rsp_resp, rsp_latency}, 0);

    // Zero-wait write then read back.
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(cyc);
    chk("wr_rsp_cycle", cyc, 3);
    chk("wr_rsp", {rsp_resp, rsp_write, rsp_latency, rsp_rdata}, {2'b00, 1'b1, 16'd2, 32'h0});
    consume();
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(cyc);
    chk("rd_rsp_cycle", cyc, 3);
    chk("rd_rsp", {rsp_resp, rsp_write, rsp_latency, rsp_rdata}, {2'b00, 1'b0, 16'd2, 32'hDEAD_BEEF});
    consume();

    // Partial strobe write.
    issue(1'b1, 32'h10, 32'h1122_3344, 4'b0101);
    wait_rsp(cyc);
    chk("strb_wr_resp", rsp_resp, 0);
    consume();
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(cyc);
    chk("strb_rd_data", rsp_rdata, 32'hDE22_BE44);
    consume();
    model[4] = 32'hDE22_BE44;

    // Response back-pressure with the next command already waiting.
    issue(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
    wait_rsp(cyc);
    model[8] = 32'hCAFE_F00D;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_rsp", {rsp_valid, cmd_ready, rsp_write, rsp_resp, rsp_latency, rsp_rdata},
          {1'b1, 1'b0, 1'b1, 2'b00, 16'd2, 32'h0});
    end
    consume();
    chk("hold_next_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_next_arvalid", M_AXI_ARVALID, 1);
    wait_rsp(cyc);
    chk("hold_next_rdata", rsp_rdata, 32'hCAFE_F00D);
    consume();

    // SLVERR pass-through.
    issue(1'b0, 32'h3FC, 32'h0, 4'h0);
    wait_rsp(cyc);
    chk("slverr_resp", rsp_resp, 2'b10);
    consume();
    chk("slverr_idle", cmd_ready, 1);

    // Random slave waits, write/read pairs against the bench model.
    rnd = 1'b1; mon_en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      idx = $urandom_range(0, 254);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      issue(1'b1, {22'h0, idx[7:0], 2'b00}, d, s);
      wait_rsp(cyc);
      chk("rnd_wr_resp", rsp_resp, 0);
      consume();
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      exp_d = model[idx];
      issue(1'b0, {22'h0, idx[7:0], 2'b00}, 32'h0, 4'h0);
      wait_rsp(cyc);
      chk("rnd_rd_data", {rsp_resp, rsp_rdata}, {2'b00, exp_d});
      consume();
    end
    rnd = 1'b0; mon_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while waiting for BVALID.
    hold_b = 1'b1;
    issue(1'b1, 32'h30, 32'h5555_AAAA, 4'hF);
    n = 0;
    while (!M_AXI_BREADY && n < 50) begin @(negedge clk); n++; end
    chk("wresp_reached", {M_AXI_BREADY, M_AXI_BVALID}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid}, 0);
    rst = 1'b0; hold_b = 1'b0;
    @(negedge clk);
    chk("midreset_cmd_ready", cmd_ready, 1);
    issue(1'b1, 32'h40, 32'h0BAD_F00D, 4'hF);
    wait_rsp(cyc);
    chk("post_reset_wr", {rsp_resp, rsp_latency}, {2'b00, 16'd2});
    consume();
    issue(1'b0, 32'h40, 32'h0, 4'h0);
    wait_rsp(cyc);
    chk("post_reset_rd", rsp_rdata, 32'h0BAD_F00D);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
